// File: rtl/mem_wb_pipe_n.sv
// MEM->WB pipeline register for an N-lane in-order core: two-entry (main + skid) buffer with trap kill and retire counting.
// Latency: a bundle captured from EMPTY is presented on the WB side one cycle later; commits happen in the pop cycle.
// Backpressure: in_ready drops only when both entries are full, so it is registered-state only and never depends on out_ready.
//
// Ports:
//   clk, rstn                 clock and asynchronous active-low reset
//   in_valid / in_ready       MEM-side bundle handshake
//   in_lane_vld, in_wen, in_rd, in_wdata, in_pc, in_trap   per-lane MEM bundle fields
//   flush                     discard everything buffered plus any incoming bundle
//   intr_taken                interrupt this cycle: the head still pops but nothing retires or writes
//   out_valid / out_ready     WB-side bundle handshake
//   out_lane_vld, out_wen, out_rd, out_wdata, out_pc, out_trap   per-lane WB bundle fields
//   commit                    per-lane retire strobe for this cycle
//   retire_cnt                64-bit running count of retired lanes (wraps)
module mem_wb_pipe_n #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES-1:0]        in_wen,
  input  logic [LANES*IDX_W-1:0]  in_rd,
  input  logic [LANES*XLEN-1:0]   in_wdata,
  input  logic [LANES*ADDR_W-1:0] in_pc,
  input  logic [LANES-1:0]        in_trap,
  input  logic                    flush,
  input  logic                    intr_taken,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES-1:0]        out_wen,
  output logic [LANES*IDX_W-1:0]  out_rd,
  output logic [LANES*XLEN-1:0]   out_wdata,
  output logic [LANES*ADDR_W-1:0] out_pc,
  output logic [LANES-1:0]        out_trap,
  output logic [LANES-1:0]        commit,
  output logic [63:0]             retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;

  // Main entry (drives the outputs) and skid entry (second bundle while WB stalls).
  logic [LANES-1:0]        m_vld, m_wen, m_trap;
  logic [LANES*IDX_W-1:0]  m_rd;
  logic [LANES*XLEN-1:0]   m_wdata;
  logic [LANES*ADDR_W-1:0] m_pc;

  logic [LANES-1:0]        s_vld, s_wen, s_trap;
  logic [LANES*IDX_W-1:0]  s_rd;
  logic [LANES*XLEN-1:0]   s_wdata;
  logic [LANES*ADDR_W-1:0] s_pc;

  // Lane qualifiers after trap kill, computed on the incoming bundle.
  logic [LANES-1:0] cap_vld, cap_wen, cap_trap;

  logic accept;
  logic pop;
  logic [63:0] commit_sum;

  // The oldest trapping lane survives as a non-writing trap marker; every
  // younger lane is squashed. Trap/wen bits of invalid lanes are cleared so
  // the stored qualifiers are self-consistent.
  always_comb begin
    logic killed;
    killed   = 1'b0;
    cap_vld  = '0;
    cap_wen  = '0;
    cap_trap = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!killed && in_lane_vld[i]) begin
        cap_vld[i] = 1'b1;
        if (in_trap[i]) begin
          cap_trap[i] = 1'b1;
          killed      = 1'b1;
        end else begin
          cap_wen[i] = in_wen[i];
        end
      end
    end
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Lane qualifiers are masked with out_valid so stale main-entry contents
  // never look live once the buffer has drained.
  assign out_lane_vld = m_vld & {LANES{out_valid}};
  assign out_trap     = m_trap & {LANES{out_valid}};
  assign out_rd       = m_rd;
  assign out_wdata    = m_wdata;
  assign out_pc       = m_pc;

  // Interrupts and flushes suppress architectural side effects but not the pop.
  assign out_wen = m_wen & out_lane_vld & {LANES{~intr_taken & ~flush}};
  assign commit  = out_lane_vld & {LANES{out_ready & ~intr_taken & ~flush}};

  always_comb begin
    commit_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      commit_sum = commit_sum + {63'd0, commit[i]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= EMPTY;
      m_vld   <= '0;
      m_wen   <= '0;
      m_trap  <= '0;
      m_rd    <= '0;
      m_wdata <= '0;
      m_pc    <= '0;
      s_vld   <= '0;
      s_wen   <= '0;
      s_trap  <= '0;
      s_rd    <= '0;
      s_wdata <= '0;
      s_pc    <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      m_vld  <= '0;
      m_wen  <= '0;
      m_trap <= '0;
      s_vld  <= '0;
      s_wen  <= '0;
      s_trap <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_vld   <= cap_vld;
            m_wen   <= cap_wen;
            m_trap  <= cap_trap;
            m_rd    <= in_rd;
            m_wdata <= in_wdata;
            m_pc    <= in_pc;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            s_vld   <= cap_vld;
            s_wen   <= cap_wen;
            s_trap  <= cap_trap;
            s_rd    <= in_rd;
            s_wdata <= in_wdata;
            s_pc    <= in_pc;
            state   <= TWO;
          end else if (accept && pop) begin
            // Head leaves while the new bundle replaces it directly in main.
            m_vld   <= cap_vld;
            m_wen   <= cap_wen;
            m_trap  <= cap_trap;
            m_rd    <= in_rd;
            m_wdata <= in_wdata;
            m_pc    <= in_pc;
          end else if (pop) begin
            m_vld  <= '0;
            m_wen  <= '0;
            m_trap <= '0;
            state  <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            m_vld   <= s_vld;
            m_wen   <= s_wen;
            m_trap  <= s_trap;
            m_rd    <= s_rd;
            m_wdata <= s_wdata;
            m_pc    <= s_pc;
            s_vld   <= '0;
            s_wen   <= '0;
            s_trap  <= '0;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + commit_sum;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_n.sv
module tb_mem_wb_pipe_n;
  localparam int L  = 2;
  localparam int XL = 32;
  localparam int AW = 32;
  localparam int IW = 5;

  logic              clk;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic [L-1:0]      in_lane_vld;
  logic [L-1:0]      in_wen;
  logic [L*IW-1:0]   in_rd;
  logic [L*XL-1:0]   in_wdata;
  logic [L*AW-1:0]   in_pc;
  logic [L-1:0]      in_trap;
  logic              flush;
  logic              intr_taken;
  logic              out_valid;
  logic              out_ready;
  logic [L-1:0]      out_lane_vld;
  logic [L-1:0]      out_wen;
  logic [L*IW-1:0]   out_rd;
  logic [L*XL-1:0]   out_wdata;
  logic [L*AW-1:0]   out_pc;
  logic [L-1:0]      out_trap;
  logic [L-1:0]      commit;
  logic [63:0]       retire_cnt;

  mem_wb_pipe_n #(.LANES(L), .XLEN(XL), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_wen(in_wen), .in_rd(in_rd),
    .in_wdata(in_wdata), .in_pc(in_pc), .in_trap(in_trap),
    .flush(flush), .intr_taken(intr_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_wen(out_wen), .out_rd(out_rd),
    .out_wdata(out_wdata), .out_pc(out_pc), .out_trap(out_trap),
    .commit(commit), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two bundles, stored already trap-killed.
  typedef struct packed {
    logic [L-1:0]    vld;
    logic [L-1:0]    wen;
    logic [L-1:0]    trap;
    logic [L*IW-1:0] rd;
    logic [L*XL-1:0] wdata;
    logic [L*AW-1:0] pc;
  } bndl_t;

  bndl_t       q[$];
  logic [63:0] cnt_m;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Oldest trapping lane is kept as a non-writing trap marker, younger lanes vanish.
  function automatic bndl_t capture();
    bndl_t b;
    bit    seen_trap;
    seen_trap = 0;
    b.rd    = in_rd;
    b.wdata = in_wdata;
    b.pc    = in_pc;
    for (int i = 0; i < L; i++) begin
      b.vld[i]  = in_lane_vld[i] && !seen_trap;
      b.trap[i] = b.vld[i] && in_trap[i];
      b.wen[i]  = b.vld[i] && in_wen[i] && !in_trap[i];
      if (in_lane_vld[i] && in_trap[i]) seen_trap = 1;
    end
    return b;
  endfunction

  task automatic set_in(input bit v, input logic [L-1:0] lv, input logic [L-1:0] wen,
                        input logic [L-1:0] trp, input bit fl, input bit intr, input bit ordy);
    in_valid    = v;
    in_lane_vld = lv;
    in_wen      = wen;
    in_trap     = trp;
    flush       = fl;
    intr_taken  = intr;
    out_ready   = ordy;
    in_rd       = (L*IW)'($urandom);
    in_wdata    = {$urandom, $urandom};
    in_pc       = {$urandom, $urandom};
  endtask

  // Check every output against the model, then advance one clock.
  task automatic step(input string tag);
    bndl_t        h;
    bndl_t        nb;
    logic [L-1:0] e_commit;
    logic [L-1:0] e_wen;
    bit           e_valid;
    bit           e_ready;
    bit           acc;
    bit           pop;
    #1;
    e_valid = (q.size() != 0);
    e_ready = (q.size() < 2);
    h = e_valid ? q[0] : '0;
    e_wen    = (e_valid && !intr_taken && !flush) ? h.wen : '0;
    e_commit = (e_valid && out_ready && !intr_taken && !flush) ? h.vld : '0;
    chk($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(e_valid));
    chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'(e_ready));
    chk($sformatf("%s.lane_vld", tag), 64'(out_lane_vld), 64'(h.vld));
    chk($sformatf("%s.trap", tag), 64'(out_trap), 64'(h.trap));
    chk($sformatf("%s.wen", tag), 64'(out_wen), 64'(e_wen));
    chk($sformatf("%s.commit", tag), 64'(commit), 64'(e_commit));
    chk($sformatf("%s.retire_cnt", tag), retire_cnt, cnt_m);
    if (e_valid) begin
      for (int i = 0; i < L; i++) begin
        if (h.vld[i]) begin
          chk($sformatf("%s.rd%0d", tag, i), 64'(out_rd[i*IW +: IW]), 64'(h.rd[i*IW +: IW]));
          chk($sformatf("%s.wdata%0d", tag, i), 64'(out_wdata[i*XL +: XL]), 64'(h.wdata[i*XL +: XL]));
          chk($sformatf("%s.pc%0d", tag, i), 64'(out_pc[i*AW +: AW]), 64'(h.pc[i*AW +: AW]));
        end
      end
    end
    acc = in_valid && e_ready && !flush;
    pop = e_valid && out_ready;
    nb  = capture();
    @(posedge clk);
    cnt_m = cnt_m + 64'($countones(e_commit));
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(nb);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cnt_m  = '0;
    rstn   = 1'b1;
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    #1 rstn = 1'b0;
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.lane_vld", 64'(out_lane_vld), 64'd0);
    chk("rst.wen", 64'(out_wen), 64'd0);
    chk("rst.trap", 64'(out_trap), 64'd0);
    chk("rst.commit", 64'(commit), 64'd0);
    chk("rst.retire_cnt", retire_cnt, 64'd0);
    chk("rst.rd", 64'(out_rd), 64'd0);
    chk("rst.pc", out_pc, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Streaming: 4 two-lane bundles at full rate, each retiring both lanes.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 2'b11, 2'b11, 2'b00, 0, 0, 1);
      step($sformatf("stream%0d", i));
    end
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("stream_drain");
    step("stream_idle");
    chk("stream.retire8", retire_cnt, 64'd8);

    // Stall: A and B fill both entries, then drain in order.
    set_in(1, 2'b11, 2'b01, 2'b00, 0, 0, 0);
    step("stallA");
    set_in(1, 2'b01, 2'b01, 2'b00, 0, 0, 0);
    step("stallB");
    set_in(1, 2'b11, 2'b11, 2'b00, 0, 0, 0);
    step("stall_full");
    chk("stall.in_ready_low", 64'(in_ready), 64'd0);
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("popA");
    step("popB");
    step("stall_empty");
    chk("stall.in_ready_back", 64'(in_ready), 64'd1);

    // Trap on lane 0 kills lane 1.
    set_in(1, 2'b11, 2'b11, 2'b01, 0, 0, 1);
    step("trap_cap");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    #1;
    chk("trap.lane_vld", 64'(out_lane_vld), 64'd1);
    chk("trap.wen", 64'(out_wen), 64'd0);
    chk("trap.commit", 64'(commit), 64'd1);
    step("trap_pop");
    // Trap on lane 1 only: lane 0 writes, lane 1 becomes the marker.
    set_in(1, 2'b11, 2'b11, 2'b10, 0, 0, 1);
    step("trap1_cap");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("trap1_pop");

    // Flush while full with a same-cycle incoming bundle.
    set_in(1, 2'b11, 2'b11, 2'b00, 0, 0, 0);
    step("flA");
    step("flB");
    set_in(1, 2'b11, 2'b11, 2'b00, 1, 0, 1);
    step("flush");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("post_flush");
    chk("flush.out_valid", 64'(out_valid), 64'd0);

    // Interrupt during pop: bundle leaves, nothing retires.
    set_in(1, 2'b11, 2'b11, 2'b00, 0, 0, 0);
    step("intr_cap");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 1, 1);
    step("intr_pop");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("intr_after");

    // Retire counter wrap.
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.retire_cnt;
    cnt_m = 64'hFFFF_FFFF_FFFF_FFFF;
    set_in(1, 2'b11, 2'b00, 2'b00, 0, 0, 1);
    step("wrap1_cap");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("wrap1_pop");
    step("wrap1_idle");
    chk("wrap.to1", retire_cnt, 64'd1);
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.retire_cnt;
    cnt_m = 64'hFFFF_FFFF_FFFF_FFFE;
    set_in(1, 2'b11, 2'b00, 2'b00, 0, 0, 1);
    step("wrap0_cap");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    step("wrap0_pop");
    step("wrap0_idle");
    chk("wrap.to0", retire_cnt, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 7, 2'($urandom), 2'($urandom),
             ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 6);
      step($sformatf("rnd%0d", i));
    end

    // Mid-operation reset discards buffered bundles at once.
    set_in(1, 2'b11, 2'b11, 2'b00, 0, 0, 0);
    step("mrA");
    step("mrB");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.in_ready", 64'(in_ready), 64'd1);
    chk("mrst.lane_vld", 64'(out_lane_vld), 64'd0);
    chk("mrst.retire_cnt", retire_cnt, 64'd0);
    q.delete();
    cnt_m = '0;
    @(negedge clk);
    rstn = 1'b1;
    set_in(1, 2'b11, 2'b11, 2'b00, 0, 0, 1);
    step("mrst_first_acc");
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    #1 chk("mrst.first_out", 64'(out_valid), 64'd1);
    step("mrst_pop");
    step("mrst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe_n.md
MEM_WB_PIPE_N -- requirements
Module: mem_wb_pipe_n

Interface
REQ-001 SHALL have parameter LANES, default 2: number of issue lanes; lane 0 is oldest in program order.
REQ-002 SHALL have parameter XLEN, default 32: register data width.
REQ-003 SHALL have parameter ADDR_W, default 32: instruction address width.
REQ-004 SHALL have parameter IDX_W, default 5: register index width.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  MEM bundle present
- in_ready  out  1  block can accept a bundle
- in_lane_vld  in  LANES  lane holds an uncancelled instruction
- in_wen  in  LANES  lane writes rd
- in_rd  in  LANES*IDX_W  destination indices
- in_wdata  in  LANES*XLEN  writeback data
- in_pc  in  LANES*ADDR_W  instruction addresses
- in_trap  in  LANES  lane raises exception or interrupt marker
- flush  in  1  kill all buffered and incoming bundles
- intr_taken  in  1  interrupt taken this cycle
- out_valid  out  1  WB bundle present
- out_ready  in  1  WB consumes the bundle; low = hold
- out_lane_vld  out  LANES  lane valid after trap kill
- out_wen  out  LANES  qualified register write enable
- out_rd, out_wdata, out_pc  out  per-lane buses as in_*
- out_trap  out  LANES  trap marker of the surviving lane
- commit  out  LANES  lane retires this cycle
- retire_cnt  out  64  running count of committed lanes

Function
REQ-006 SHALL hold at most two bundles, in a main entry and a skid entry; occupancy states are EMPTY, ONE and TWO.
REQ-007 SHALL drive in_ready = 1 when the state is not TWO; in_ready SHALL NOT depend combinationally on out_ready.
REQ-008 SHALL accept a bundle on in_valid & in_ready & !flush.
REQ-009 SHALL pop the head on out_valid & out_ready.
REQ-010 State transitions:
- EMPTY to ONE on accept.
- ONE to TWO on accept without pop.
- ONE to EMPTY on pop without accept.
- TWO to ONE on pop; the skid entry moves to main.
- Simultaneous accept and pop in ONE stays in ONE, with the new bundle in main.
REQ-011 SHALL drive out_valid = 1 when the state is not EMPTY; outputs SHALL come from the main entry only.
REQ-012 SHALL apply a trap kill at capture: for the lowest lane k with in_lane_vld[k] & in_trap[k], lanes j>k SHALL be stored with lane_vld=0.
REQ-013 Under the same trap kill, lane k SHALL be stored with lane_vld=1, wen=0, trap=1.
REQ-014 SHALL drive out_wen[i] = stored wen[i] & out_lane_vld[i] & out_valid & !intr_taken.
REQ-015 SHALL drive commit[i] = out_valid & out_ready & out_lane_vld[i] & !intr_taken; commit SHALL be 0 whenever out_ready=0.
REQ-016 SHALL still pop the bundle normally when intr_taken=1, with zero commits and zero writes.
REQ-017 SHALL, on flush, discard both entries and go to EMPTY on the next edge, ignoring any same-cycle accept.
REQ-018 During a flush cycle, commit and out_wen SHALL be forced to 0.
REQ-019 SHALL add popcount(commit) to retire_cnt at each edge, wrapping modulo 2^64.
REQ-020 SHALL retire within the same cycle as the pop; capture-to-output latency SHALL be 1 cycle from EMPTY.
REQ-021 SHALL leave data fields of invalid lanes unspecified, but SHALL gate out_wen and commit for those lanes as above.

Reset
REQ-022 While rstn=0: state EMPTY, out_valid=0, in_ready=1, all lane_vld/wen/trap=0, data/pc/rd=0, commit=0, retire_cnt=0.
REQ-023 Assertion of reset mid-operation SHALL discard buffered bundles immediately; the first accept SHALL be possible on the first edge after rstn rises.

Verification
REQ-024 LANES=2, stream 4 bundles with both lanes valid, out_ready=1 -> each bundle appears 1 cycle after accept, commit=2'b11 each cycle, retire_cnt=8.
REQ-025 Accept A, B with out_ready=0 -> state TWO, in_ready=0, commit=0, out holds A; raise out_ready -> A then B popped in order, then in_ready=1.
REQ-026 in_lane_vld=2'b11, in_trap=2'b01 -> out_lane_vld=2'b01, out_wen=2'b00, out_trap=2'b01, commit=2'b01 on pop.
REQ-027 State TWO, flush=1 together with in_valid=1 -> next cycle out_valid=0, commit stays 0, retire_cnt unchanged.
REQ-028 intr_taken=1 during pop of a 2-lane bundle -> commit=0, out_wen=0, bundle removed, retire_cnt unchanged.
REQ-029 Preload retire_cnt near 2^64-1 via forced stimulus, commit 2 lanes -> retire_cnt wraps to 0 or 1 as appropriate.
